// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with wrap-bit pointers, threshold flags, error pulses and a
// selectable registered or first-word-fall-through read port.
module sync_fifo_ext #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0,
    localparam int ADDR_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, underflow_q;
    logic                  wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);

    // A request is taken on the edge where it is high and the current flag allows it;
    // rejected requests are dropped and reported by a one-cycle error pulse.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= wr_en & full;
            underflow_q <= rd_en & empty;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_addr] <= wr_data;
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    if (FWFT != 0) begin : g_fwft
        assign rd_data  = mem_q[rd_addr];
        assign rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok;
                if (rd_ok) rd_data_q <= mem_q[rd_addr];
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule
